// File: rtl/sram_arb_pkg.sv
// Shared definitions for the unified-memory SRAM arbiter: read-owner
// encoding, default geometry and the data-path width.
package sram_arb_pkg;

    localparam int DATA_W         = 32;
    localparam int ADDR_W_DEF     = 14;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

endpackage

// File: rtl/sram_arb_stat.sv
// Performance counters for the SRAM arbiter: request conflicts and the
// stall cycles seen by each requester. Counters wrap naturally at 2^32.
module sram_arb_stat
    import sram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic              dm_req,
    input  logic              if_gnt,
    input  logic              dm_gnt,
    output logic [DATA_W-1:0] stat_conflict,
    output logic [DATA_W-1:0] stat_if_stall,
    output logic [DATA_W-1:0] stat_dm_stall
);

    // Count conflict and stall cycles; everything clears while reset is held
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_conflict <= '0;
            stat_if_stall <= '0;
            stat_dm_stall <= '0;
        end else begin
            if (if_req && dm_req)
                stat_conflict <= stat_conflict + 32'd1;
            if (if_req && !if_gnt)
                stat_if_stall <= stat_if_stall + 32'd1;
            if (dm_req && !dm_gnt)
                stat_dm_stall <= stat_dm_stall + 32'd1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one synchronous single-port SRAM between the CPU fetch (IF) and
// data-memory (DM) ports. DM wins by default; after STARVE_MAX consecutive
// denied fetch cycles IF is forced to win once. Read data returns one cycle
// after the grant to whichever port owned that read.
// Optional build macro: SRAM_ARB_STAT_EN adds three performance counters.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic [3:0]        dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_read,
    output logic [3:0]        sram_write,
    output logic [DATA_W-1:0] sram_di,
    input  logic [DATA_W-1:0] sram_do
`ifdef SRAM_ARB_STAT_EN
    ,
    output logic [DATA_W-1:0] stat_conflict,
    output logic [DATA_W-1:0] stat_if_stall,
    output logic [DATA_W-1:0] stat_dm_stall
`endif
);

    owner_e     rd_owner;
    logic [3:0] starve_cnt;
    logic       forced_if;

    // Upper address bits are intentionally dropped by the SRAM word address
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W], dm_addr[31:ADDR_W]};

    assign forced_if = (starve_cnt == 4'(STARVE_MAX));

    // Pick the winner this cycle: DM unless fetch has starved long enough
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (rst) begin
            if (dm_req && !forced_if)
                dm_gnt = 1'b1;
            else if (if_req)
                if_gnt = 1'b1;
        end
    end

    // Steer the winner's address, strobes and data onto the SRAM port
    always_comb begin
        sram_addr  = '0;
        sram_read  = 1'b0;
        sram_write = 4'b0000;
        sram_di    = '0;
        if (dm_gnt) begin
            sram_addr  = dm_addr[ADDR_W-1:0];
            sram_read  = (dm_we == 4'b0000);
            sram_write = dm_we;
            sram_di    = dm_wdata;
        end else if (if_gnt) begin
            sram_addr  = if_addr[ADDR_W-1:0];
            sram_read  = 1'b1;
            sram_di    = dm_wdata;
        end
    end

    // Remember who owns next cycle's read data and track fetch starvation
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_owner   <= OWN_NONE;
            starve_cnt <= 4'd0;
        end else begin
            if (dm_gnt && (dm_we == 4'b0000))
                rd_owner <= OWN_DM;
            else if (if_gnt)
                rd_owner <= OWN_IF;
            else
                rd_owner <= OWN_NONE;

            if (!if_req || if_gnt)
                starve_cnt <= 4'd0;
            else if (starve_cnt < 4'(STARVE_MAX))
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // A response in flight when reset arrives is dropped, so gate with rst
    assign if_rvalid = rst && (rd_owner == OWN_IF);
    assign dm_rvalid = rst && (rd_owner == OWN_DM);
    assign if_rdata  = sram_do;
    assign dm_rdata  = sram_do;

`ifdef SRAM_ARB_STAT_EN
    sram_arb_stat u_stat (
        .clk           (clk),
        .rst           (rst),
        .if_req        (if_req),
        .dm_req        (dm_req),
        .if_gnt        (if_gnt),
        .dm_gnt        (dm_gnt),
        .stat_conflict (stat_conflict),
        .stat_if_stall (stat_if_stall),
        .stat_dm_stall (stat_dm_stall)
    );
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a directed vector table covering the fetch,
// store/load, starvation and reset-drop sequences, then randomized traffic
// checked against a cycle-level reference model with its own memory copy.
// Build with SRAM_ARB_STAT_EN defined to also check the counters.
module tb_sram_arbiter;

    localparam int ADDR_W     = 14;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 1 << ADDR_W;

    localparam logic [31:0] W0 = 32'h1000_0001;
    localparam logic [31:0] W1 = 32'h1000_0002;
    localparam logic [31:0] W2 = 32'h1000_0003;
    localparam logic [31:0] WB = 32'h1122_3344;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] HI = 32'hFFFF_C000;

    typedef struct {
        bit          rst;
        bit          if_req;
        logic [31:0] if_addr;
        bit          dm_req;
        logic [3:0]  dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        bit          e_if_gnt;
        bit          e_dm_gnt;
        bit          e_if_rv;
        bit          e_dm_rv;
        logic [31:0] e_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic [ADDR_W-1:0] sram_addr;
    logic        sram_read;
    logic [3:0]  sram_write;
    logic [31:0] sram_di;
    logic [31:0] sram_do = '0;
`ifdef SRAM_ARB_STAT_EN
    logic [31:0] stat_conflict;
    logic [31:0] stat_if_stall;
    logic [31:0] stat_dm_stall;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // SRAM behavioural model storage and the reference memory copy
    bit [31:0] mem     [0:DEPTH-1];
    bit [31:0] ref_mem [0:DEPTH-1];
    bit        preloaded = 1'b0;

    // Reference model state
    int        m_denied = 0;
    int        m_pend   = 0;
    bit [31:0] m_pend_data = '0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .sram_addr  (sram_addr),
        .sram_read  (sram_read),
        .sram_write (sram_write),
        .sram_di    (sram_di),
        .sram_do    (sram_do)
`ifdef SRAM_ARB_STAT_EN
        ,
        .stat_conflict (stat_conflict),
        .stat_if_stall (stat_if_stall),
        .stat_dm_stall (stat_dm_stall)
`endif
    );

    // Synchronous single-port SRAM: byte writes and registered read data
    always @(posedge clk) begin
        if (!preloaded) begin
            mem[0]      <= W0;
            mem[1]      <= W1;
            mem[2]      <= W2;
            mem[16'h100] <= WB;
            preloaded   <= 1'b1;
        end
        for (int b = 0; b < 4; b++)
            if (sram_write[b])
                mem[sram_addr][8*b +: 8] <= sram_di[8*b +: 8];
        if (sram_read)
            sram_do <= mem[sram_addr];
    end

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r, bit ir, logic [31:0] ia, bit dr,
                                logic [3:0] we, logic [31:0] da, logic [31:0] wd,
                                bit eig, bit edg, bit eirv, bit edrv,
                                logic [31:0] erd);
        vec_t v;
        v.rst = r; v.if_req = ir; v.if_addr = ia; v.dm_req = dr;
        v.dm_we = we; v.dm_addr = da; v.dm_wdata = wd;
        v.e_if_gnt = eig; v.e_dm_gnt = edg; v.e_if_rv = eirv; v.e_dm_rv = edrv;
        v.e_rdata = erd;
        return v;
    endfunction

    // Drive one cycle, check the DUT against table or model, advance the model
    task automatic apply_stimulus(input vec_t v, input bit use_table);
        bit          forced, e_ig, e_dg, e_irv, e_drv, e_rd;
        int unsigned a;
        logic [3:0]  e_wr;
        logic [31:0] e_di;

        @(negedge clk);
        rst = v.rst; if_req = v.if_req; if_addr = v.if_addr;
        dm_req = v.dm_req; dm_we = v.dm_we; dm_addr = v.dm_addr;
        dm_wdata = v.dm_wdata;
        #2;

        forced = (m_denied == STARVE_MAX);
        e_dg = v.rst && v.dm_req && !forced;
        e_ig = v.rst && v.if_req && !e_dg;
        e_irv = v.rst && (m_pend == 1);
        e_drv = v.rst && (m_pend == 2);
        a = e_dg ? (v.dm_addr % DEPTH) : (e_ig ? (v.if_addr % DEPTH) : 0);
        e_rd = e_ig || (e_dg && (v.dm_we == 4'b0000));
        e_wr = e_dg ? v.dm_we : 4'b0000;
        e_di = (e_ig || e_dg) ? v.dm_wdata : 32'h0;

        if (use_table) begin
            check_output("if_gnt",    32'(if_gnt),    32'(v.e_if_gnt));
            check_output("dm_gnt",    32'(dm_gnt),    32'(v.e_dm_gnt));
            check_output("if_rvalid", 32'(if_rvalid), 32'(v.e_if_rv));
            check_output("dm_rvalid", 32'(dm_rvalid), 32'(v.e_dm_rv));
            if (v.e_if_rv) check_output("if_rdata", if_rdata, v.e_rdata);
            if (v.e_dm_rv) check_output("dm_rdata", dm_rdata, v.e_rdata);
        end else begin
            check_output("if_gnt",    32'(if_gnt),    32'(e_ig));
            check_output("dm_gnt",    32'(dm_gnt),    32'(e_dg));
            check_output("if_rvalid", 32'(if_rvalid), 32'(e_irv));
            check_output("dm_rvalid", 32'(dm_rvalid), 32'(e_drv));
            if (e_irv) check_output("if_rdata", if_rdata, m_pend_data);
            if (e_drv) check_output("dm_rdata", dm_rdata, m_pend_data);
        end
        check_output("sram_addr",  32'(sram_addr),  a);
        check_output("sram_read",  32'(sram_read),  32'(e_rd));
        check_output("sram_write", 32'(sram_write), 32'(e_wr));
        if (e_dg || !e_ig) check_output("sram_di", sram_di, e_di);

        if (!v.rst) begin
            m_denied = 0;
            m_pend   = 0;
        end else begin
            if (v.if_req && !e_ig)
                m_denied = (m_denied + 1 > STARVE_MAX) ? STARVE_MAX : m_denied + 1;
            else
                m_denied = 0;
            m_pend = e_rd ? (e_dg ? 2 : 1) : 0;
            if (e_rd) m_pend_data = ref_mem[a];
            for (int b = 0; b < 4; b++)
                if (e_wr[b]) ref_mem[a][8*b +: 8] = v.dm_wdata[8*b +: 8];
        end
        cyc++;
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;

        rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0;
        dm_we = '0; dm_addr = '0; dm_wdata = '0;
        ref_mem[0] = W0; ref_mem[1] = W1; ref_mem[2] = W2; ref_mem[16'h100] = WB;

        //            rst ifr if_addr  dmr we    dm_addr       wdata        ig dg irv drv rdata
        tbl.push_back(mk(0, 1, 32'h0,  1, 4'h0, 32'h2000,     32'h0,       0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,  0, 4'h0, 32'h0,        32'h0,       0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h0,  0, 4'h0, 32'h0,        32'h0,       1, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h1,  0, 4'h0, 32'h0,        32'h0,       1, 0, 1, 0, W0));
        tbl.push_back(mk(1, 1, 32'h2,  0, 4'h0, 32'h0,        32'h0,       1, 0, 1, 0, W1));
        tbl.push_back(mk(1, 0, 32'h0,  0, 4'h0, 32'h0,        32'h0,       0, 0, 1, 0, W2));
        tbl.push_back(mk(1, 0, 32'h0,  1, 4'hF, 32'h2000,     DB,          0, 1, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0,  1, 4'h0, 32'h2000,     32'h0,       0, 1, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0,  0, 4'h0, 32'h0,        32'h0,       0, 0, 0, 1, DB));
        tbl.push_back(mk(1, 0, 32'h0,  1, 4'h1, 32'h100,      32'hAA,      0, 1, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0,  1, 4'h0, 32'h100,      32'h0,       0, 1, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0,  0, 4'h0, 32'h0,        32'h0,       0, 0, 0, 1, 32'h1122_33AA));
        // Both requesters held: DM x4 then forced IF, twice
        tbl.push_back(mk(1, 1, HI,     1, 4'h0, HI | 32'h2000, 32'h0,      0, 1, 0, 0, 32'h0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 1, HI, 1, 4'h0, HI | 32'h2000, 32'h0,      0, 1, 0, 1, DB));
        tbl.push_back(mk(1, 1, HI,     1, 4'h0, HI | 32'h2000, 32'h0,      1, 0, 0, 1, DB));
        tbl.push_back(mk(1, 1, HI,     1, 4'h0, HI | 32'h2000, 32'h0,      0, 1, 1, 0, W0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 1, HI, 1, 4'h0, HI | 32'h2000, 32'h0,      0, 1, 0, 1, DB));
        tbl.push_back(mk(1, 1, HI,     1, 4'h0, HI | 32'h2000, 32'h0,      1, 0, 0, 1, DB));
        // IF read granted, then reset drops its response; count restarts
        tbl.push_back(mk(1, 1, 32'h1,  0, 4'h0, 32'h0,        32'h0,       1, 0, 1, 0, W0));
        tbl.push_back(mk(0, 1, 32'h0,  1, 4'h0, 32'h2000,     32'h0,       0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h0,  1, 4'h0, 32'h2000,     32'h0,       0, 1, 0, 0, 32'h0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 1, 32'h0, 1, 4'h0, 32'h2000,  32'h0,       0, 1, 0, 1, DB));
        tbl.push_back(mk(1, 1, 32'h0,  1, 4'h0, 32'h2000,     32'h0,       1, 0, 0, 1, DB));
        tbl.push_back(mk(1, 0, 32'h0,  0, 4'h0, 32'h0,        32'h0,       0, 0, 1, 0, W0));

        foreach (tbl[i]) apply_stimulus(tbl[i], 1'b1);

        // Randomized traffic on a small address window to force reuse
        for (int i = 0; i < 400; i++) begin
            v = mk(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0);
            v.rst      = ($urandom_range(0, 39) != 0);
            v.if_req   = ($urandom_range(0, 9) < 7);
            v.dm_req   = ($urandom_range(0, 9) < 7);
            v.if_addr  = ($urandom() & HI) | 32'($urandom_range(0, 15));
            v.dm_addr  = ($urandom() & HI) | 32'($urandom_range(0, 15));
            v.dm_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            v.dm_wdata = $urandom();
            apply_stimulus(v, 1'b0);
        end

`ifdef SRAM_ARB_STAT_EN
        apply_stimulus(mk(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0), 1'b0);
        for (int i = 0; i < 10; i++)
            apply_stimulus(mk(1, 1, 32'h3, 1, 4'h0, 32'h5, 32'h0, 0, 0, 0, 0, 32'h0), 1'b0);
        apply_stimulus(mk(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0), 1'b0);
        check_output("stat_conflict", stat_conflict, 32'd10);
        check_output("stat_stall_sum", stat_if_stall + stat_dm_stall, 32'd10);
        check_output("stat_if_stall", stat_if_stall, 32'd8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
